// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: DMType codes, arbiter FSM state encoding and the access legality check
// shared by the mem_port_arbiter block.
package mem_arb_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_ISSUE = 3'b001,
        ST_WAIT  = 3'b010,
        ST_RESP  = 3'b011,
        ST_ERR   = 3'b100
    } arb_state_e;

    // True when the DMType code is defined and the address is naturally aligned for it
    function automatic logic access_ok(input logic [2:0] dm_type, input logic [1:0] addr_lo);
        logic ok_v;
        case (dm_type)
            DM_WORD:            ok_v = (addr_lo == 2'b00);
            DM_HALF, DM_HALF_U: ok_v = (addr_lo[0] == 1'b0);
            DM_BYTE, DM_BYTE_U: ok_v = 1'b1;
            default:            ok_v = 1'b0;
        endcase
        return ok_v;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner selection. Channels are scanned starting at ptr and
// wrapping around; the first requesting channel wins. With ptr tied to zero this is
// plain fixed priority (lowest index wins).
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int N_CH = 2
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] ptr,
    output logic [$clog2(N_CH)-1:0] winner,
    output logic                    any_req
);
    localparam int IW = $clog2(N_CH);

    int   sum_s;
    logic hit_s;
    logic found_s;

    // Rotating scan from the pointer; the first hit is latched through found_s
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        sum_s   = 0;
        hit_s   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            sum_s   = (int'(ptr) + k) % N_CH;
            hit_s   = |(req & (N_CH'(1) << sum_s));
            winner  = winner | ({IW{hit_s & ~found_s}} & IW'(sum_s));
            found_s = found_s | hit_s;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between N_CH masters.
// One access in flight at a time: IDLE -> ISSUE -> WAIT* -> RESP, or IDLE -> ERR for
// misaligned / undefined-DMType requests. Payload is captured at grant.
// Optional build macro MEM_ARB_RR_EN selects round-robin arbitration instead of fixed
// priority (channel 0 highest).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ch_req,
    input  logic [N_CH-1:0]         ch_we,
    input  logic [3*N_CH-1:0]       ch_type,
    input  logic [AW*N_CH-1:0]      ch_addr,
    input  logic [DW*N_CH-1:0]      ch_wdata,
    output logic [DW*N_CH-1:0]      ch_rdata,
    output logic [N_CH-1:0]         ch_ready,
    output logic [N_CH-1:0]         ch_err,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [2:0]              mem_type,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata,
    output logic                    busy,
    output logic [$clog2(N_CH)-1:0] gnt_idx
);
    localparam int IW = $clog2(N_CH);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    gnt_q, gnt_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [2:0]       type_q, type_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [N_CH-1:0]  ch_ready_q, ch_ready_d;
    logic [N_CH-1:0]  ch_err_q, ch_err_d;
    logic             busy_q, busy_d;

    logic [IW-1:0]    ptr_s;
    logic [IW-1:0]    win_s;
    logic             any_req_s;
    logic             sel_we_s;
    logic [2:0]       sel_type_s;
    logic [AW-1:0]    sel_addr_s;
    logic [DW-1:0]    sel_wdata_s;
    logic             sel_ok_s;
    logic             hit_s;
    logic             resp_rd_s;

`ifdef MEM_ARB_RR_EN
    logic [IW-1:0]    ptr_q, ptr_d;
    assign ptr_s = ptr_q;
`else
    assign ptr_s = '0;
`endif

    arb_pick #(.N_CH(N_CH)) u_pick (
        .req     (ch_req),
        .ptr     (ptr_s),
        .winner  (win_s),
        .any_req (any_req_s)
    );

    // Route the winning channel's payload towards the capture registers
    always_comb begin
        sel_we_s    = 1'b0;
        sel_type_s  = 3'b000;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        hit_s       = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            hit_s       = (win_s == IW'(k));
            sel_we_s    = sel_we_s | (hit_s & ch_we[k]);
            sel_type_s  = sel_type_s | ({3{hit_s}} & ch_type[3*k +: 3]);
            sel_addr_s  = sel_addr_s | ({AW{hit_s}} & ch_addr[AW*k +: AW]);
            sel_wdata_s = sel_wdata_s | ({DW{hit_s}} & ch_wdata[DW*k +: DW]);
        end
        sel_ok_s = access_ok(sel_type_s, sel_addr_s[1:0]);
    end

    // Next-state and next-output computation; outputs are registered from these values
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        type_d     = type_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        ch_ready_d = '0;
        ch_err_d   = '0;
`ifdef MEM_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    gnt_d   = win_s;
                    we_d    = sel_we_s;
                    type_d  = sel_type_s;
                    addr_d  = sel_addr_s;
                    wdata_d = sel_wdata_s;
`ifdef MEM_ARB_RR_EN
                    if (int'(win_s) == N_CH - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_s + IW'(1);
                    end
`endif
                    if (sel_ok_s) begin
                        state_d  = ST_ISSUE;
                        mem_en_d = 1'b1;
                        mem_we_d = sel_we_s;
                    end else begin
                        state_d           = ST_ERR;
                        ch_ready_d[win_s] = 1'b1;
                        ch_err_d[win_s]   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (MEM_LAT == 1) begin
                    state_d           = ST_RESP;
                    ch_ready_d[gnt_q] = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 2'(MEM_LAT - 1);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d           = ST_RESP;
                    ch_ready_d[gnt_q] = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Single state/output register bank with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            cnt_q      <= 2'd0;
            we_q       <= 1'b0;
            type_q     <= DM_WORD;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            ch_ready_q <= '0;
            ch_err_q   <= '0;
            busy_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            ch_ready_q <= ch_ready_d;
            ch_err_q   <= ch_err_d;
            busy_q     <= busy_d;
`ifdef MEM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Read data is a passthrough of the memory in the RESP cycle, granted channel only
    always_comb begin
        ch_rdata  = '0;
        resp_rd_s = (state_q == ST_RESP) && !we_q;
        for (int k = 0; k < N_CH; k++) begin
            ch_rdata[DW*k +: DW] = {DW{resp_rd_s && (gnt_q == IW'(k))}} & mem_rdata;
        end
    end

    assign ch_ready  = ch_ready_q;
    assign ch_err    = ch_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_type  = type_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign gnt_idx   = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of mem_port_arbiter against a
// transaction-level model (arbitration rule, alignment rule, word memory image).
// dut0: N_CH=3, MEM_LAT=1. dut1: N_CH=2, MEM_LAT=3 (latency and reset behaviour).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, fill;

    logic [2:0]  req0, we0, ready0, err0;
    logic [8:0]  type0;
    logic [95:0] addr0, wdata0, rdata0;
    logic        men0, mwe0, busy0;
    logic [2:0]  mtype0;
    logic [31:0] maddr0, mwdata0, mrdata0;
    logic [1:0]  gnt0;

    logic [1:0]  req1, we1, ready1, err1;
    logic [5:0]  type1;
    logic [63:0] addr1, wdata1, rdata1;
    logic        men1, mwe1, busy1;
    logic [2:0]  mtype1;
    logic [31:0] maddr1, mwdata1, mrdata1;
    logic [0:0]  gnt1;

    mem_port_arbiter #(.N_CH(3), .AW(32), .DW(32), .MEM_LAT(LAT0)) dut0 (
        .clk(clk), .rst(rst0), .ch_req(req0), .ch_we(we0), .ch_type(type0),
        .ch_addr(addr0), .ch_wdata(wdata0), .ch_rdata(rdata0), .ch_ready(ready0),
        .ch_err(err0), .mem_en(men0), .mem_we(mwe0), .mem_type(mtype0),
        .mem_addr(maddr0), .mem_wdata(mwdata0), .mem_rdata(mrdata0),
        .busy(busy0), .gnt_idx(gnt0)
    );

    mem_port_arbiter #(.N_CH(2), .AW(32), .DW(32), .MEM_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst1), .ch_req(req1), .ch_we(we1), .ch_type(type1),
        .ch_addr(addr1), .ch_wdata(wdata1), .ch_rdata(rdata1), .ch_ready(ready1),
        .ch_err(err1), .mem_en(men1), .mem_we(mwe1), .mem_type(mtype1),
        .mem_addr(maddr1), .mem_wdata(mwdata1), .mem_rdata(mrdata1),
        .busy(busy1), .gnt_idx(gnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int k);
        if (k == 4) return 32'hDEAD_BEEF;
        return 32'hA500_0000 ^ (32'(k) * 32'h0001_0103);
    endfunction

    // Environment memories: word-wide, write at the mem_en edge, read data after latency
    logic [31:0] env_mem0 [64];
    logic [31:0] env_mem1 [64];
    logic [31:0] pipe1 [3];
    logic [31:0] ref_mem0 [64];

    always @(posedge clk) begin
        if (fill) begin
            for (int k = 0; k < 64; k++) env_mem0[k] <= init_word(k);
        end else if (men0 && mwe0) begin
            env_mem0[maddr0[7:2]] <= mwdata0;
        end
        mrdata0 <= (men0 && !mwe0) ? env_mem0[maddr0[7:2]] : 32'hBAD0_BAD0;
    end

    always @(posedge clk) begin
        if (fill) begin
            for (int k = 0; k < 64; k++) env_mem1[k] <= init_word(k);
        end else if (men1 && mwe1) begin
            env_mem1[maddr1[7:2]] <= mwdata1;
        end
        pipe1[0] <= (men1 && !mwe1) ? env_mem1[maddr1[7:2]] : 32'hBAD1_BAD1;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign mrdata1 = pipe1[2];

`ifdef MEM_ARB_RR_EN
    int rr_ptr = 0;
`endif

    // Winner among pending channels according to the configured arbitration rule
    function automatic int model_pick(input logic [2:0] pend);
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 3; k++) if (pend[(rr_ptr + k) % 3]) return (rr_ptr + k) % 3;
`else
        for (int k = 0; k < 3; k++) if (pend[k]) return k;
`endif
        return 0;
    endfunction

    // Access size in bytes from DMType; undefined codes and misalignment are illegal
    function automatic bit model_legal(input logic [2:0] t, input logic [31:0] a);
        int sz;
        sz = (t == 3'd0) ? 4 : (t == 3'd1 || t == 3'd2) ? 2 : (t == 3'd3 || t == 3'd4) ? 1 : 0;
        if (sz == 0) return 1'b0;
        return (int'(a[1:0]) % sz) == 0;
    endfunction

    // Present a set of requests on dut0 and check every completion against the model
    task automatic do_round(input logic [2:0] mask, input logic [2:0] wes, input logic [8:0] types,
                            input logic [95:0] addrs, input logic [95:0] wds,
                            input bit mutate, input bit keep, input int n_txn);
        logic [2:0]  pend;
        logic [31:0] a, wd;
        logic [2:0]  t;
        logic [95:0] exp_rd;
        int g, cnt, en_seen, done, exp_lat;
        bit legal, first, got;
        req0 = mask; we0 = wes; type0 = types; addr0 = addrs; wdata0 = wds;
        pend = mask; first = 1'b1; done = 0;
        while (pend != 3'b000 && done < n_txn) begin
            g  = model_pick(pend);
            a  = addrs[32*g +: 32];
            wd = wds[32*g +: 32];
            t  = types[3*g +: 3];
            legal = model_legal(t, a);
            exp_lat = (first ? 1 : 2) + (legal ? LAT0 : 0);
            cnt = 0; en_seen = 0; got = 1'b0;
            while (!got && cnt < 20) begin
                @(negedge clk);
                cnt++;
                if (men0) begin
                    en_seen++;
                    check_eq("mem_addr", maddr0, a);
                    check_eq("mem_we", mwe0, wes[g]);
                    check_eq("mem_type", mtype0, t);
                    check_eq("mem_wdata", mwdata0, wd);
                    if (mutate) begin
                        req0[g] = 1'b0;
                        addr0[32*g +: 32]  = $urandom;
                        wdata0[32*g +: 32] = $urandom;
                    end
                end
                if (ready0 != 3'b000) got = 1'b1;
                else check_eq("rdata_idle", rdata0, 96'd0);
            end
            check_eq("ready_seen", got, 1);
            check_eq("latency", cnt, exp_lat);
            check_eq("ready_vec", ready0, 3'b001 << g);
            check_eq("err_vec", err0, legal ? 3'b000 : (3'b001 << g));
            check_eq("gnt_idx", gnt0, g);
            check_eq("mem_en_count", en_seen, legal ? 1 : 0);
            exp_rd = '0;
            if (legal && !wes[g]) exp_rd[32*g +: 32] = ref_mem0[a[7:2]];
            check_eq("rdata", rdata0, exp_rd);
            if (legal && wes[g]) ref_mem0[a[7:2]] = wd;
`ifdef MEM_ARB_RR_EN
            rr_ptr = (g + 1) % 3;
`endif
            if (!keep) begin
                pend[g] = 1'b0;
                req0[g] = 1'b0;
            end
            first = 1'b0;
            done++;
            if (!got) pend = 3'b000;
        end
        req0 = 3'b000;
        @(negedge clk);
        check_eq("idle_after", busy0, 1'b0);
    endtask

    logic [2:0]  r_mask, r_we;
    logic [8:0]  r_type;
    logic [95:0] r_addr, r_wd;
    int          tv, lo, cnt1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 64; k++) ref_mem0[k] = init_word(k);
        fill = 1'b1; rst0 = 1'b1; rst1 = 1'b1;
        req0 = 3'b111; we0 = 3'b000; type0 = '0; addr0 = '0; wdata0 = '0;
        req1 = 2'b11;  we1 = 2'b00;  type1 = '0; addr1 = '0; wdata1 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy0", busy0, 1'b0);
        check_eq("rst_men0", men0, 1'b0);
        check_eq("rst_mwe0", mwe0, 1'b0);
        check_eq("rst_mtype0", mtype0, DM_WORD);
        check_eq("rst_maddr0", maddr0, 32'd0);
        check_eq("rst_mwdata0", mwdata0, 32'd0);
        check_eq("rst_ready0", ready0, 3'b000);
        check_eq("rst_err0", err0, 3'b000);
        check_eq("rst_rdata0", rdata0, 96'd0);
        check_eq("rst_gnt0", gnt0, 2'd0);
        check_eq("rst_busy1", busy1, 1'b0);
        check_eq("rst_men1", men1, 1'b0);
        check_eq("rst_gnt1", gnt1, 1'b0);
        req0 = 3'b000; req1 = 2'b00;
        fill = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        // All channels requesting continuously: grant order follows the arbitration rule
        do_round(3'b111, 3'b000, 9'd0, {32'h48, 32'h44, 32'h40}, 96'd0, 1'b0, 1'b1, 6);
        // ch0 word read of 0x10 returns the preloaded word
        do_round(3'b001, 3'b000, 9'd0, {32'h0, 32'h0, 32'h10}, 96'd0, 1'b0, 1'b0, 3);
        // ch0 write 0x20 and ch1 read 0x20 raised together
        do_round(3'b011, 3'b001, 9'd0, {32'h0, 32'h20, 32'h20},
                 {32'h0, 32'h0, 32'h1234_5678}, 1'b0, 1'b0, 3);
        // ch1 misaligned word read errors; a byte read of the same address succeeds
        do_round(3'b010, 3'b000, 9'd0, {32'h0, 32'h13, 32'h0}, 96'd0, 1'b0, 1'b0, 3);
        do_round(3'b010, 3'b000, {3'b000, DM_BYTE, 3'b000}, {32'h0, 32'h13, 32'h0},
                 96'd0, 1'b0, 1'b0, 3);
        // Half access at odd address and an undefined DMType both error
        do_round(3'b101, 3'b000, {3'b111, 3'b000, DM_HALF_U}, {32'h8, 32'h0, 32'h21},
                 96'd0, 1'b0, 1'b0, 3);

        for (int r = 0; r < 40; r++) begin
            r_mask = 3'($urandom_range(1, 7));
            r_we   = 3'($urandom);
            for (int c = 0; c < 3; c++) begin
                tv = int'($urandom_range(0, 9));
                if (tv > 7) tv = 0;
                r_type[3*c +: 3] = 3'(tv);
                lo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0;
                r_addr[32*c +: 32] = 32'(int'($urandom_range(0, 63)) * 4 + lo);
                r_wd[32*c +: 32]   = $urandom;
            end
            do_round(r_mask, r_we, r_type, r_addr, r_wd, 1'($urandom_range(0, 1)), 1'b0, 3);
        end

        // dut1: latency-3 read on ch1
        req1 = 2'b10; we1 = 2'b00; type1 = '0; addr1 = {32'h8, 32'h0}; wdata1 = '0;
        cnt1 = 0;
        while (ready1 == 2'b00 && cnt1 < 20) begin
            @(negedge clk);
            cnt1++;
        end
        check_eq("lat3_latency", cnt1, LAT1 + 1);
        check_eq("lat3_ready", ready1, 2'b10);
        check_eq("lat3_err", err1, 2'b00);
        check_eq("lat3_rdata", rdata1, {init_word(2), 32'h0});
        check_eq("lat3_gnt", gnt1, 1'b1);
        req1 = 2'b00;
        @(negedge clk);
        check_eq("lat3_idle", busy1, 1'b0);

        // dut1: reset during WAIT discards the read
        req1 = 2'b01; addr1 = {32'h0, 32'h0};
        @(negedge clk);
        check_eq("rst_mid_men", men1, 1'b1);
        @(negedge clk);
        rst1 = 1'b1; req1 = 2'b00;
        @(negedge clk);
        check_eq("rst_mid_busy", busy1, 1'b0);
        check_eq("rst_mid_men0", men1, 1'b0);
        check_eq("rst_mid_ready_a", ready1, 2'b00);
        rst1 = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_ready_b", ready1, 2'b00);
        @(negedge clk);
        check_eq("rst_mid_ready_c", ready1, 2'b00);
        check_eq("rst_mid_busy_c", busy1, 1'b0);

        // dut1: a write whose mem_en cycle completed before reset stays committed
        req1 = 2'b01; we1 = 2'b01; addr1 = {32'h0, 32'h4}; wdata1 = {32'h0, 32'hCAFE_F00D};
        @(negedge clk);
        check_eq("wr_men", men1, 1'b1);
        check_eq("wr_mwe", mwe1, 1'b1);
        @(negedge clk);
        rst1 = 1'b1; req1 = 2'b00; we1 = 2'b00;
        @(negedge clk);
        rst1 = 1'b0;
        check_eq("wr_rst_ready", ready1, 2'b00);
        @(negedge clk);
        req1 = 2'b01; addr1 = {32'h0, 32'h4};
        cnt1 = 0;
        while (ready1 == 2'b00 && cnt1 < 20) begin
            @(negedge clk);
            cnt1++;
        end
        check_eq("wr_commit_lat", cnt1, LAT1 + 1);
        check_eq("wr_commit_data", rdata1, {32'h0, 32'hCAFE_F00D});
        req1 = 2'b00;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
